// File: rtl/sb_rx_pkg.sv
// Shared types and constants for the switchboard receive endpoint.
package sb_rx_pkg;

  typedef enum logic [1:0] {
    MODE_ALWAYS    = 2'd0,
    MODE_ALTERNATE = 2'd1,
    MODE_RANDOM    = 2'd2
  } mode_e;

  typedef enum logic [0:0] {
    StIdle,
    StPresent
  } pace_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/sb_lfsr16.sv
// 16-bit Fibonacci LFSR, free-running from a fixed seed; pacing source for sb_rx_fifo.
module sb_lfsr16
  import sb_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] out
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign out = lfsr_q;

endmodule

// File: rtl/sb_rx_fifo.sv
// Switchboard receive endpoint: elastic FIFO with mode-paced output valid and packet counter.
// Optional SB_RX_FRAME_CHECK_EN adds a sticky frame_err for dest changes inside a packet.
module sb_rx_fifo
  import sb_rx_pkg::*;
#(
  parameter int unsigned DW                 = 416,
  parameter int unsigned DEPTH              = 4,
  parameter logic [1:0]  VALID_MODE_DEFAULT = 2'd0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic [31:0]   in_dest,
  input  logic          in_last,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] data,
  output logic [31:0]   dest,
  output logic          last,
  output logic          valid,
  input  logic          ready,
  input  logic          mode_wr,
  input  logic [1:0]    mode_in,
  output logic [31:0]   pkt_count
`ifdef SB_RX_FRAME_CHECK_EN
  ,
  output logic          frame_err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_data [DEPTH];
  logic [31:0]   mem_dest [DEPTH];
  logic          mem_last [DEPTH];

  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_d;
  logic          full, push, pop;
  logic [1:0]    mode_q, mode_d;
  logic [31:0]   pkt_count_q;
  logic [15:0]   lfsr, lfsr_nxt;
  logic          gate_next, back_to_back;
  pace_state_e   state_q, state_d;

  sb_lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .out (lfsr)
  );

  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign valid    = (state_q == StPresent);
  assign pop      = valid && ready;

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  assign count_d  = wr_ptr_d - rd_ptr_d;
  assign mode_d   = mode_wr ? mode_in : mode_q;
  assign lfsr_nxt = lfsr_next(lfsr);

  assign data = mem_data[rd_ptr_q[AW-1:0]];
  assign dest = mem_dest[rd_ptr_q[AW-1:0]];
  assign last = mem_last[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q[AW-1:0]] <= in_data;
      mem_dest[wr_ptr_q[AW-1:0]] <= in_dest;
      mem_last[wr_ptr_q[AW-1:0]] <= in_last;
    end
  end

  // The FSM decides next-cycle valid from next-cycle occupancy and gate, so a word
  // pushed at one edge can be presented in the very next cycle.
  always_comb begin
    gate_next = 1'b1;
    case (mode_d)
      MODE_ALTERNATE: gate_next = !pop;
      MODE_RANDOM:    gate_next = lfsr_nxt[0];
      default:        gate_next = 1'b1;
    endcase
    back_to_back = (mode_d != MODE_ALTERNATE) && (mode_d != MODE_RANDOM);

    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if ((count_d != '0) && gate_next) state_d = StPresent;
      end
      StPresent: begin
        if (pop) state_d = ((count_d != '0) && back_to_back) ? StPresent : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mode_q      <= VALID_MODE_DEFAULT;
      state_q     <= StIdle;
      pkt_count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mode_q   <= mode_d;
      state_q  <= state_d;
      if (pop && last) pkt_count_q <= pkt_count_q + 32'd1;
    end
  end

  assign pkt_count = pkt_count_q;

`ifdef SB_RX_FRAME_CHECK_EN
  logic        in_pkt_q;
  logic [31:0] first_dest_q;
  logic        frame_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_pkt_q     <= 1'b0;
      first_dest_q <= '0;
      frame_err_q  <= 1'b0;
    end else if (push) begin
      if (in_pkt_q && (in_dest != first_dest_q)) frame_err_q <= 1'b1;
      if (!in_pkt_q) first_dest_q <= in_dest;
      in_pkt_q <= !in_last;
    end
  end

  assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_sb_rx_fifo.sv
// Self-checking bench for sb_rx_fifo: queue-based reference model plus directed/random tests.
module tb_sb_rx_fifo;

  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic [31:0]   in_dest = '0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] data;
  logic [31:0]   dest;
  logic          last;
  logic          valid;
  logic          ready = 1'b0;
  logic          mode_wr = 1'b0;
  logic [1:0]    mode_in = 2'd0;
  logic [31:0]   pkt_count;
`ifdef SB_RX_FRAME_CHECK_EN
  logic          frame_err;
`endif

  sb_rx_fifo #(
    .DW                 (DW),
    .DEPTH              (DEPTH),
    .VALID_MODE_DEFAULT (2'd0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data      (data),
    .dest      (dest),
    .last      (last),
    .valid     (valid),
    .ready     (ready),
    .mode_wr   (mode_wr),
    .mode_in   (mode_in),
    .pkt_count (pkt_count)
`ifdef SB_RX_FRAME_CHECK_EN
    ,
    .frame_err (frame_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of words, the pacing rules, and the spec's LFSR.
  typedef struct packed {
    logic [DW-1:0] d;
    logic [31:0]   de;
    logic          l;
  } word_t;

  word_t       mq[$];
  word_t       m_head;
  logic        m_valid;
  logic [1:0]  m_mode;
  logic [15:0] m_lfsr;
  logic [31:0] m_pkts;
  logic        m_pop, m_push, m_gate;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {b, s[15:1]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_valid = 1'b0;
      m_mode  = 2'd0;
      m_lfsr  = 16'hACE1;
      m_pkts  = '0;
    end else begin
      m_push = in_valid && (mq.size() < DEPTH);
      m_pop  = m_valid && ready;
      if (m_pop) begin
        m_head = mq.pop_front();
        if (m_head.l) m_pkts = m_pkts + 32'd1;
      end
      if (m_push) mq.push_back({in_data, in_dest, in_last});
      if (mode_wr) m_mode = mode_in;
      m_lfsr = lfsr_step(m_lfsr);
      case (m_mode)
        2'd1:    m_gate = !m_pop;
        2'd2:    m_gate = m_lfsr[0];
        default: m_gate = 1'b1;
      endcase
      if (m_pop) m_valid = (mq.size() != 0) && (m_mode == 2'd0 || m_mode == 2'd3);
      else if (!m_valid) m_valid = (mq.size() != 0) && m_gate;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", valid, m_valid);
      chk("in_ready", in_ready, mq.size() < DEPTH);
      chk("pkt_count", pkt_count, m_pkts);
      if (m_valid && mq.size() != 0) begin
        chk("data", data, mq[0].d);
        chk("dest", dest, mq[0].de);
        chk("last", last, mq[0].l);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [31:0] de, input logic l);
    logic fire;
    int   n;
    n        = 0;
    in_data  = d;
    in_dest  = de;
    in_last  = l;
    in_valid = 1'b1;
    forever begin
      fire = in_ready;
      tick();
      if (fire) break;
      n++;
      if (n > 2000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stayed low for %0d cycles, required a push", n);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    ready = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (mq.size() == 0) break;
      tick();
    end
    tick();
    chk("drained_valid", valid, 1'b0);
    chk("drained_in_ready", in_ready, 1'b1);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    ready    = 1'b0;
    mode_wr  = 1'b0;
    #1;
    chk("rst_valid", valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_pkt_count", pkt_count, 32'd0);
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_valid", valid, 1'b0);
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode_in = m;
    mode_wr = 1'b1;
    tick();
    mode_wr = 1'b0;
  endtask

  logic [6:0] pat;
  logic       done;

  initial begin
    // Test 1: mode 0, three single-word packets back to back
    do_reset();
    ready = 1'b1;
    send({$urandom, $urandom}, 32'h10, 1'b1);
    chk("t1_first_valid", valid, 1'b1);
    chk("t1_first_dest", dest, 32'h10);
    send({$urandom, $urandom}, 32'h11, 1'b1);
    send({$urandom, $urandom}, 32'h12, 1'b1);
    drain();
    chk("t1_pkt_count", pkt_count, 32'd3);

    // Test 2: fill with ready low, then release
    do_reset();
    fork
      begin
        for (int k = 0; k < 6; k++) send({$urandom, $urandom}, 32'h40 + k, k == 5);
      end
      begin
        repeat (10) tick();
        chk("t2_in_ready_full", in_ready, 1'b0);
        chk("t2_valid_held", valid, 1'b1);
        ready = 1'b1;
      end
    join
    drain();
    chk("t2_pkt_count", pkt_count, 32'd1);

    // Test 3: alternate mode gives one idle cycle between pops
    do_reset();
    set_mode(2'd1);
    for (int k = 0; k < 4; k++) send({$urandom, $urandom}, 32'h50 + k, 1'b1);
    tick();
    ready = 1'b1;
    pat = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      pat = {pat[5:0], valid};
    end
    chk("t3_valid_pattern", pat, 7'b1010101);
    drain();
    chk("t3_pkt_count", pkt_count, 32'd4);

    // Test 4: random mode, random backpressure, 20 packets of 5 words
    do_reset();
    set_mode(2'd2);
    done = 1'b0;
    fork
      begin
        while (!done) begin
          ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
      begin
        for (int p = 0; p < 20; p++) begin
          for (int w = 0; w < 5; w++) begin
            repeat ($urandom_range(0, 1)) tick();
            send({$urandom, $urandom}, 32'h100 + p, w == 4);
          end
        end
        done = 1'b1;
      end
    join
    drain();
    chk("t4_pkt_count", pkt_count, 32'd20);

    // Test 5: asynchronous reset mid-packet
    do_reset();
    ready = 1'b1;
    send({$urandom, $urandom}, 32'h60, 1'b1);
    repeat (2) tick();
    chk("t5_pkt_count_before", pkt_count, 32'd1);
    ready = 1'b0;
    for (int k = 0; k < 3; k++) send({$urandom, $urandom}, 32'h61, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_valid", valid, 1'b0);
    chk("t5_async_in_ready", in_ready, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;
    tick();
    chk("t5_pkt_count_after", pkt_count, 32'd0);
    chk("t5_in_ready_after", in_ready, 1'b1);
    repeat (2) tick();
    chk("t5_empty_valid", valid, 1'b0);

`ifdef SB_RX_FRAME_CHECK_EN
    do_reset();
    ready = 1'b1;
    chk("fe_reset", frame_err, 1'b0);
    send({$urandom, $urandom}, 32'h10, 1'b0);
    send({$urandom, $urandom}, 32'h20, 1'b1);
    chk("fe_set", frame_err, 1'b1);
    send({$urandom, $urandom}, 32'h30, 1'b0);
    send({$urandom, $urandom}, 32'h30, 1'b1);
    drain();
    chk("fe_sticky", frame_err, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
